msk_skid_buffer: RTL and testbench
==================================

MSK_SKID_BUFFER -- requirements
Module: msk_skid_buffer

Interface
REQ-001 SHALL have parameter d, default 2: number of shares per masked bit.
REQ-002 SHALL have parameter count, default 1: number of masked bits per word; masked word width is count*d, shares-interleaved per bit as in the existing masked gadgets.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: upstream word available.
REQ-006 SHALL have port in_ready, output, 1: buffer accepts a word this cycle.
REQ-007 SHALL have port in_data, input, count*d: masked input word.
REQ-008 SHALL have port out_valid, output, 1: out_data holds a valid word.
REQ-009 SHALL have port out_ready, input, 1: downstream consumes the word this cycle.
REQ-010 SHALL have port out_data, output, count*d: masked output word, driven directly from a register.
REQ-011 SHALL have port flush, input, 1: synchronous discard of all held words; present only when MSK_SKID_FLUSH_EN is defined.

Function
REQ-012 SHALL define input fire = in_valid & in_ready and output fire = out_valid & out_ready.
REQ-013 SHALL hold at most two words: main register (drives out_data) and skid register.
REQ-014 SHALL implement states EMPTY, ONE (main valid), FULL (main and skid valid).
REQ-015 SHALL transition EMPTY->ONE on input fire, loading main with in_data.
REQ-016 SHALL in ONE: input and output fire -> ONE, main loads in_data; input fire only -> FULL, skid loads in_data; output fire only -> EMPTY.
REQ-017 SHALL in FULL: output fire -> ONE, main loads skid contents; otherwise hold.
REQ-018 SHALL drive in_ready from a register, 1 in EMPTY and ONE, 0 in FULL.
REQ-019 SHALL set out_valid = 1 exactly in ONE and FULL.
REQ-020 SHALL give latency 1 cycle from input fire to out_valid in EMPTY, and sustain one word per cycle when out_ready stays high.
REQ-021 SHALL preserve word order and never drop or duplicate a word.
REQ-022 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL never combine shares of one bit; each data bit is moved share-wise only, through enable-gated masked registers.
REQ-024 SHALL load data registers only on the enables above; no data register toggles on any other cycle.

Reset
REQ-025 SHALL force state EMPTY, out_valid=0, in_ready=0 while rst=1, asynchronously.
REQ-026 SHALL raise in_ready on the first rising clk edge after rst deasserts.
REQ-027 SHALL NOT reset data registers; their contents are don't-care while out_valid=0.

Configuration
REQ-028 SHALL, with MSK_SKID_FLUSH_EN defined, on flush=1 enter EMPTY at the next edge, overriding any simultaneous input fire (the word is discarded), with in_ready=1 next cycle.
REQ-029 SHALL, without MSK_SKID_FLUSH_EN, omit the flush port and flush logic entirely.

Structure
REQ-030 SHALL place state encoding constants (EMPTY, ONE, FULL) in the shared masked-gadget package/header.
REQ-031 SHALL instantiate MSKregEn twice (main and skid) as its only data sub-module; no other masked logic.

Verification (d=2, count=8)
REQ-032 SHALL check reset: assert rst mid-FULL -> out_valid=0, in_ready=0 immediately; after release in_ready=1 on next edge.
REQ-033 SHALL check single word: push 0x3C (random shares) in EMPTY, out_ready=1 -> out_valid next cycle, unmasked out=0x3C, EMPTY after.
REQ-034 SHALL check backpressure: push 0x11, 0x22 with out_ready=0 -> FULL, in_ready=0, out stable at 0x11; release -> 0x11 then 0x22.
REQ-035 SHALL check streaming: 16 words 0x00..0x0F, in_valid=out_ready=1 -> one output per cycle, in order, no gaps.
REQ-036 SHALL check random valid/ready toggling over 10000 cycles -> scoreboard match and share-wise data equal to inputs.
REQ-037 SHALL check, with MSK_SKID_FLUSH_EN, flush in FULL with concurrent in_valid -> EMPTY next cycle, no stale word ever output.

Source files
------------

// File: rtl/msk_skid_buffer_pkg.sv
// Shared definitions for the masked skid buffer: occupancy state encoding.
package msk_skid_buffer_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } skid_state_e;

    function automatic logic skid_has_word(input skid_state_e s);
        return s != StEmpty;
    endfunction

endpackage

// File: rtl/MSKregEn.sv
// Enable-gated masked register: holds count*d shares, loads share-wise only when en=1.
module MSKregEn #(
    parameter int unsigned count = 1,
    parameter int unsigned d     = 2
) (
    input  logic               clk,
    input  logic               en,
    input  logic [count*d-1:0] in,
    output logic [count*d-1:0] out
);

    logic [count*d-1:0] out_q;

    // No reset: contents are don't-care until qualified by the owner's valid state.
    always_ff @(posedge clk) begin
        if (en) begin
            out_q <= in;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/msk_skid_buffer.sv
// Two-entry skid buffer for masked words; out_data and in_ready come straight from registers.
// Optional synchronous flush port is built only when MSK_SKID_FLUSH_EN is defined.
module msk_skid_buffer
    import msk_skid_buffer_pkg::*;
#(
    parameter int unsigned d     = 2,
    parameter int unsigned count = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [count*d-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef MSK_SKID_FLUSH_EN
    input  logic               flush,
`endif
    output logic [count*d-1:0] out_data
);

    localparam int unsigned W = count * d;

    skid_state_e    state_q, state_d;
    logic           in_ready_q, in_ready_d;
    logic           in_fire, out_fire;
    logic           main_en, skid_en, main_from_skid;
    logic [W-1:0]   main_in, skid_out;

    assign out_valid = skid_has_word(state_q);
    assign in_ready  = in_ready_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    state_d = StOne;
                    main_en = 1'b1;
                end
            end
            StOne: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    state_d = StFull;
                    skid_en = 1'b1;
                end else if (out_fire) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_fire) begin
                    state_d        = StOne;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
`ifdef MSK_SKID_FLUSH_EN
        // Flush wins over a concurrent input fire; the incoming word is dropped.
        if (flush) begin
            state_d = StEmpty;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
`endif
        in_ready_d = (state_d != StFull);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Whole-word select between two masked sources; shares are never combined.
    assign main_in = main_from_skid ? skid_out : in_data;

    MSKregEn #(
        .count(count),
        .d    (d)
    ) u_main_reg (
        .clk(clk),
        .en (main_en),
        .in (main_in),
        .out(out_data)
    );

    MSKregEn #(
        .count(count),
        .d    (d)
    ) u_skid_reg (
        .clk(clk),
        .en (skid_en),
        .in (in_data),
        .out(skid_out)
    );

endmodule

// File: tb/tb_msk_skid_buffer.sv
// Directed and randomised checks of msk_skid_buffer with d=2, count=8.
module tb_msk_skid_buffer;

    localparam int unsigned D   = 2;
    localparam int unsigned CNT = 8;
    localparam int unsigned W   = D * CNT;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
`ifdef MSK_SKID_FLUSH_EN
    logic         flush;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    msk_skid_buffer #(
        .d    (D),
        .count(CNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef MSK_SKID_FLUSH_EN
        .flush    (flush),
`endif
        .out_data (out_data)
    );

    function automatic logic [W-1:0] mask_word(input logic [CNT-1:0] v);
        logic [W-1:0] m;
        logic         r;
        for (int i = 0; i < CNT; i++) begin
            r          = 1'($urandom_range(0, 1));
            m[2*i]     = r;
            m[2*i + 1] = r ^ v[i];
        end
        return m;
    endfunction

    function automatic logic [CNT-1:0] unmask_word(input logic [W-1:0] m);
        logic [CNT-1:0] v;
        for (int i = 0; i < CNT; i++) v[i] = m[2*i] ^ m[2*i + 1];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #3;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: valid=%b ready=%b, required 0 0", out_valid, in_ready);
        end
        step(); step();
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_pre_edge: in_ready=%b, required 0", in_ready);
        end
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_edge: ready=%b valid=%b, required 1 0", in_ready, out_valid);
        end
        in_valid = 1'b1; in_data = mask_word(8'hA1);
        step();
        in_data = mask_word(8'hA2);
        step();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_fill_full: ready=%b valid=%b, required 0 1", in_ready, out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_full: valid=%b ready=%b, required 0 0", out_valid, in_ready);
        end
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rerelease: ready=%b valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        logic [W-1:0] w;
        w = mask_word(8'h3C);
        in_valid = 1'b1; in_data = w; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== w) begin
            n_fail++;
            $display("FAIL single_out: valid=%b data=%h, required 1 %h", out_valid, out_data, w);
        end
        n_checks++;
        if (unmask_word(out_data) !== 8'h3C) begin
            n_fail++;
            $display("FAIL single_unmasked: got %h, required 3c", unmask_word(out_data));
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_empty: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w1, w2;
        w1 = mask_word(8'h11);
        w2 = mask_word(8'h22);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = w1;
        step();
        in_data = w2;
        step();
        in_data = mask_word(8'h33);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== w1) begin
            n_fail++;
            $display("FAIL bp_full: ready=%b valid=%b data=%h, required 0 1 %h",
                     in_ready, out_valid, out_data, w1);
        end
        step();
        n_checks++;
        if (in_ready !== 1'b0 || out_data !== w1) begin
            n_fail++;
            $display("FAIL bp_stable: ready=%b data=%h, required 0 %h", in_ready, out_data, w1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== w2 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: valid=%b data=%h ready=%b, required 1 %h 1",
                     out_valid, out_data, in_ready, w2);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drained: valid=%b, required 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_streaming();
        logic [W-1:0] w;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w = mask_word(CNT'(i));
            in_valid = 1'b1; in_data = w;
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== w || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_%0d: valid=%b data=%h ready=%b, required 1 %h 1",
                         i, out_valid, out_data, in_ready, w);
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: valid=%b, required 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        logic [W-1:0] w, exp_w;
        for (int cyc = 0; cyc < 10004; cyc++) begin
            if (cyc < 10000) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            w = mask_word(CNT'($urandom));
            in_data = w;
            n_checks++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_flags cyc %0d: valid=%b ready=%b, required %b %b", cyc,
                         out_valid, in_ready, q.size() != 0, q.size() < 2);
            end
            if (out_valid === 1'b1 && out_ready && q.size() != 0) begin
                exp_w = q.pop_front();
                n_checks++;
                if (out_data !== exp_w) begin
                    n_fail++;
                    $display("FAIL rand_data cyc %0d: got %h, required %h", cyc, out_data, exp_w);
                end
            end
            if (in_valid && in_ready === 1'b1) q.push_back(w);
            step();
        end
        n_checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_drain: left=%0d valid=%b, required 0 0", q.size(), out_valid);
        end
        out_ready = 1'b0;
    endtask

`ifdef MSK_SKID_FLUSH_EN
    task automatic test_flush();
        logic [W-1:0] w;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = mask_word(8'h44);
        step();
        in_data = mask_word(8'h55);
        step();
        in_data = mask_word(8'h66);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_empty: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_stale_%0d: valid=%b, required 0", i, out_valid);
            end
        end
        w = mask_word(8'h77);
        in_valid = 1'b1; in_data = w;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== w) begin
            n_fail++;
            $display("FAIL flush_resume: valid=%b data=%h, required 1 %h", out_valid, out_data, w);
        end
        step();
        out_ready = 1'b0;
    endtask
`endif

    initial begin
`ifdef MSK_SKID_FLUSH_EN
        flush = 1'b0;
`endif
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
`ifdef MSK_SKID_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
